// File: rtl/dist32_pkg.sv
// dist32 shared definitions: operand/leaf geometry and the per-node record.
package dist_pkg;

    localparam int DATA_W = 32;
    localparam int LEAVES = 32;
    localparam int LEVELS = $clog2(LEAVES);

    // One switch-node register as seen by a reader of the tree. The mask
    // field is sized for the root; deeper levels only use the low
    // LEAVES >> level bits.
    typedef struct packed {
        logic              active;
        logic [LEAVES-1:0] mask;
        logic [DATA_W-1:0] data;
    } node_t;

endpackage

// File: rtl/dist32_if.sv
// dist32 operand/leaf bus: buffer-side handshake in, leaf lanes out.
interface dist32_if;
    import dist_pkg::*;

    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_W-1:0]        in_data;
    logic [LEAVES-1:0]        in_mask;
    logic                     out_ready;
    logic [LEAVES-1:0]        out_valid;
    logic [LEAVES*DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_data, in_mask, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_mask, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/dist32_node.sv
// dist_node: one 1-to-2 switch of the distribution tree. The parent mask
// slice is split in halves; a child whose half is nonzero becomes active and
// captures the parent data, an idle child keeps its old data untouched.
module dist_node
    import dist_pkg::*;
#(
    parameter int SLICE_W = 2
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              p_active,
    input  logic [DATA_W-1:0] p_data,
    input  logic [SLICE_W-1:0] p_mask,
    output logic              c0_active,
    output logic [DATA_W-1:0] c0_data,
    output logic              c1_active,
    output logic [DATA_W-1:0] c1_data
);

    localparam int HALF = SLICE_W / 2;

    logic lo_hit;
    logic hi_hit;

    assign lo_hit = p_active & (|p_mask[HALF-1:0]);
    assign hi_hit = p_active & (|p_mask[SLICE_W-1:HALF]);

    // Child registers: activity always follows the parent, data only moves into active children.
    always_ff @(posedge clk) begin
        if (rst) begin
            c0_active <= 1'b0;
            c1_active <= 1'b0;
            c0_data   <= '0;
            c1_data   <= '0;
        end else if (en) begin
            c0_active <= lo_hit;
            c1_active <= hi_hit;
            if (lo_hit) begin
                c0_data <= p_data;
            end
            if (hi_hit) begin
                c1_data <= p_data;
            end
        end
    end

endmodule

// File: rtl/dist32.sv
// dist32: pipelined 32-leaf multicast tree. One register level per tree
// level; the top owns the stage-valid chain, the elastic advance logic,
// the per-level mask copies and the accept/drop counters.
module dist32
    import dist_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    dist32_if.slave     bus,
    output logic [15:0] pkt_cnt,
    output logic [15:0] drop_cnt
);

    logic [LEVELS:1] v;
    logic [LEVELS:1] adv;
    logic [LEVELS:1] lvl_en;
    logic            mask_nz;
    logic            accept;
    logic            load_root;
    logic [LEAVES-1:0] mask_q [LEVELS-1:1];

    assign mask_nz   = |bus.in_mask;
    assign bus.in_ready = ~rst & (~v[1] | adv[1]);
    assign accept    = bus.in_valid & bus.in_ready;
    assign load_root = accept & mask_nz;

    // Advance ripples back from the leaves; a level only loads when its source holds a real operand, so bubbles move without toggling node data.
    always_comb begin
        adv    = '0;
        lvl_en = '0;
        adv[LEVELS] = bus.out_ready;
        for (int l = LEVELS - 1; l >= 1; l--) begin
            adv[l] = ~v[l+1] | adv[l+1];
        end
        lvl_en[1] = load_root;
        for (int l = 2; l <= LEVELS; l++) begin
            lvl_en[l] = adv[l-1] & v[l-1];
        end
    end

    // Stage-valid chain: level 1 takes a nonzero-mask accept, deeper levels take their upstream valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
        end else begin
            if (bus.in_ready) begin
                v[1] <= load_root;
            end
            for (int l = 2; l <= LEVELS; l++) begin
                if (adv[l-1]) begin
                    v[l] <= v[l-1];
                end
            end
        end
    end

    // Full operand mask travels alongside each level so every node can pick its own slice.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int l = 1; l < LEVELS; l++) begin
                mask_q[l] <= '0;
            end
        end else begin
            if (lvl_en[1]) begin
                mask_q[1] <= bus.in_mask;
            end
            for (int l = 2; l < LEVELS; l++) begin
                if (lvl_en[l]) begin
                    mask_q[l] <= mask_q[l-1];
                end
            end
        end
    end

    // Accepted operands are counted as delivered or dropped depending on whether any leaf was addressed.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt  <= '0;
            drop_cnt <= '0;
        end else if (accept) begin
            if (mask_nz) begin
                pkt_cnt <= pkt_cnt + 16'd1;
            end else begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    for (genvar l = 0; l <= LEVELS; l++) begin : lvl
        localparam int NODES = 1 << l;

        logic [NODES*DATA_W-1:0] data;
        logic [NODES-1:0]        act;

        if (l == 0) begin : g_src
            node_t root;
            assign root.active = mask_nz;
            assign root.mask   = bus.in_mask;
            assign root.data   = bus.in_data;
            assign data = root.data;
            assign act  = root.active;
        end else begin : g_tree
            localparam int PW = LEAVES >> (l - 1);

            for (genvar j = 0; j < NODES / 2; j++) begin : node
                logic [PW-1:0] pm;

                if (l == 1) begin : g_pm_root
                    assign pm = bus.in_mask[j*PW +: PW];
                end else begin : g_pm_inner
                    assign pm = mask_q[l-1][j*PW +: PW];
                end

                dist_node #(.SLICE_W(PW)) u_node (
                    .clk       (clk),
                    .rst       (rst),
                    .en        (lvl_en[l]),
                    .p_active  (lvl[l-1].act[j]),
                    .p_data    (lvl[l-1].data[j*DATA_W +: DATA_W]),
                    .p_mask    (pm),
                    .c0_active (act[2*j]),
                    .c0_data   (data[2*j*DATA_W +: DATA_W]),
                    .c1_active (act[2*j+1]),
                    .c1_data   (data[(2*j+1)*DATA_W +: DATA_W])
                );
            end
        end
    end

    assign bus.out_valid = {LEAVES{v[LEVELS]}} & lvl[LEVELS].act;
    assign bus.out_data  = lvl[LEVELS].data;

endmodule

// File: tb/tb_dist32.sv
// tb_dist32: table-driven vectors plus hand-written corner sequences for the
// dist32 multicast tree, checked against a leaf-side scoreboard.
module tb_dist32;
    import dist_pkg::*;

    localparam int OW = LEAVES * DATA_W;

    typedef struct {
        logic [LEAVES-1:0] valid;
        logic [DATA_W-1:0] data;
    } exp_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [LEAVES-1:0] mask;
        logic [LEAVES-1:0] exp_valid;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pkt_cnt;
    logic [15:0] drop_cnt;

    dist32_if bus();

    dist32 dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .pkt_cnt  (pkt_cnt),
        .drop_cnt (drop_cnt)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exp_t              exp_q [$];
    int                rx_cyc [$];
    logic [DATA_W-1:0] model_leaf [LEAVES];
    logic [15:0]       model_pkt;
    logic [15:0]       model_drop;
    bit                any_valid;
    bit                prev_stall;
    logic [LEAVES-1:0] prev_valid;
    logic [OW-1:0]     prev_data;

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Cycle counter used to time-stamp leaf handshakes.
    always @(posedge clk) cyc = cyc + 1;

    task automatic checkOutput(input string name, input logic [OW-1:0] act, input logic [OW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearModel();
        exp_q.delete();
        for (int i = 0; i < LEAVES; i++) model_leaf[i] = '0;
        model_pkt  = '0;
        model_drop = '0;
    endtask

    task automatic doReset(input int n);
        rst = 1'b1;
        clearModel();
        repeat (n) tick();
        rst = 1'b0;
    endtask

    // Offers one operand and waits (bounded) for acceptance; expected leaf results go to the scoreboard.
    task automatic applyStimulus(input logic [DATA_W-1:0] d, input logic [LEAVES-1:0] m,
                                 input logic [LEAVES-1:0] ev, output int waits);
        exp_t e;
        bit   ok;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_mask  = m;
        waits = 0;
        ok    = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            waits++;
            if (waits >= 50) begin
                checks++;
                errors++;
                $display("[TB] FAIL accept_timeout: waited %0d cycles required acceptance", waits);
                break;
            end
            @(posedge clk);
            #1;
        end
        if (ok) begin
            if (ev != '0) begin
                e.valid = ev;
                e.data  = d;
                exp_q.push_back(e);
            end
            if (m != '0) model_pkt++;
            else         model_drop++;
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: %0d outputs outstanding required 0", exp_q.size());
        end
        repeat (2) tick();
    endtask

    // Leaf-side monitor: pops the scoreboard on every handshake and checks stall stability.
    always @(negedge clk) begin
        exp_t          e;
        logic [OW-1:0] md;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (|bus.out_valid) any_valid = 1'b1;
            if (prev_stall) begin
                checkOutput("stall_valid_hold", bus.out_valid, prev_valid);
                checkOutput("stall_data_hold", bus.out_data, prev_data);
            end
            if (bus.out_ready && (|bus.out_valid)) begin
                if (exp_q.size() == 0) begin
                    checkOutput("spurious_output", bus.out_valid, '0);
                end else begin
                    e = exp_q.pop_front();
                    for (int i = 0; i < LEAVES; i++) begin
                        if (e.valid[i]) model_leaf[i] = e.data;
                    end
                    for (int i = 0; i < LEAVES; i++) md[i*DATA_W +: DATA_W] = model_leaf[i];
                    checkOutput("leaf_valid", bus.out_valid, e.valid);
                    checkOutput("leaf_data", bus.out_data, md);
                    rx_cyc.push_back(cyc);
                end
            end
            prev_stall = !bus.out_ready && (|bus.out_valid);
            prev_valid = bus.out_valid;
            prev_data  = bus.out_data;
        end
    end

    // Hard time limit so the bench always reaches its summary line.
    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog: simulation time expired required completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Main test sequence.
    initial begin
        vec_t tbl [16];
        int   w;
        int   acc;
        int   base;

        tbl[0]  = '{32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tbl[1]  = '{32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tbl[2]  = '{32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tbl[3]  = '{32'h0000_0004, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tbl[4]  = '{32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tbl[5]  = '{32'h0000_0006, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tbl[6]  = '{32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tbl[7]  = '{32'h0000_0008, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tbl[8]  = '{32'h0000_0011, 32'h8000_0001, 32'h8000_0001};
        tbl[9]  = '{32'h0000_0022, 32'h0000_0002, 32'h0000_0002};
        tbl[10] = '{32'h0000_0044, 32'h0000_FFFF, 32'h0000_FFFF};
        tbl[11] = '{32'h0000_0033, 32'h0000_0000, 32'h0000_0000};
        tbl[12] = '{32'h0000_0055, 32'hFFFF_0000, 32'hFFFF_0000};
        tbl[13] = '{32'h0000_0066, 32'h8000_0000, 32'h8000_0000};
        tbl[14] = '{32'h0000_0077, 32'h0F0F_0F0F, 32'h0F0F_0F0F};
        tbl[15] = '{32'h0000_0088, 32'hAAAA_AAAA, 32'hAAAA_AAAA};

        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hDEAD_BEEF;
        bus.in_mask   = '1;
        bus.out_ready = 1'b1;
        clearModel();
        any_valid = 1'b0;

        $display("[TB] reset with in_valid held high");
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("in_ready_during_rst", bus.in_ready, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("in_ready_after_rst", bus.in_ready, 1'b1);
        checkOutput("rst_out_valid", bus.out_valid, '0);
        checkOutput("rst_out_data", bus.out_data, '0);
        checkOutput("rst_pkt_cnt", pkt_cnt, 16'd0);
        checkOutput("rst_drop_cnt", drop_cnt, 16'd0);
        tick();

        $display("[TB] unicast latency");
        applyStimulus(32'hA5A5_0001, 32'h0000_0001, 32'h0000_0001, w);
        // The accepting edge loads level 1; levels 2..5 follow on the next four edges.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("unicast_not_early", bus.out_valid, '0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("unicast_valid", bus.out_valid, 32'h0000_0001);
        checkOutput("unicast_leaf0", bus.out_data[DATA_W-1:0], 32'hA5A5_0001);
        checkOutput("unicast_pkt_cnt", pkt_cnt, 16'd1);
        tick();
        drain();

        $display("[TB] vector table: broadcast stream and multicast patterns");
        base = rx_cyc.size();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(tbl[i].data, tbl[i].mask, tbl[i].exp_valid, w);
            if (i < 8) checkOutput("bcast_in_ready_wait", w, 0);
        end
        drain();
        checkOutput("bcast_consecutive", rx_cyc[base+7] - rx_cyc[base], 7);
        checkOutput("table_pkt_cnt", pkt_cnt, model_pkt);
        checkOutput("table_drop_cnt", drop_cnt, model_drop);

        $display("[TB] backpressure fill and drain");
        bus.out_ready = 1'b0;
        acc = 0;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            exp_t e;
            bus.in_data = 32'h100 + k;
            bus.in_mask = 32'h3 << (2 * k);
            @(negedge clk);
            if (!bus.in_ready) break;
            if (bus.in_mask != '0) begin
                e.valid = bus.in_mask;
                e.data  = bus.in_data;
                exp_q.push_back(e);
                model_pkt++;
            end else begin
                model_drop++;
            end
            acc++;
            tick();
        end
        checkOutput("accepts_before_full", acc, 5);
        repeat (2) begin
            tick();
            @(negedge clk);
            checkOutput("full_in_ready_low", bus.in_ready, 1'b0);
        end
        tick();
        bus.out_ready = 1'b1;
        bus.in_data   = 32'h0000_0200;
        bus.in_mask   = 32'hFFFF_FFFF;
        @(negedge clk);
        checkOutput("accept_while_draining", bus.in_ready, 1'b1);
        if (bus.in_ready) begin
            exp_t e;
            e.valid = 32'hFFFF_FFFF;
            e.data  = 32'h0000_0200;
            exp_q.push_back(e);
            model_pkt++;
        end
        tick();
        bus.in_valid = 1'b0;
        drain();
        checkOutput("bp_pkt_cnt", pkt_cnt, model_pkt);

        $display("[TB] zero mask between two operands");
        doReset(1);
        base = rx_cyc.size();
        applyStimulus(32'h0000_00C1, 32'h0000_0001, 32'h0000_0001, w);
        applyStimulus(32'h0000_0033, 32'h0000_0000, 32'h0000_0000, w);
        applyStimulus(32'h0000_00C2, 32'h0000_0002, 32'h0000_0002, w);
        drain();
        checkOutput("zero_drop_cnt", drop_cnt, 16'd1);
        checkOutput("zero_pkt_cnt", pkt_cnt, 16'd2);
        checkOutput("zero_bubble_gap", rx_cyc[base+1] - rx_cyc[base], 2);

        $display("[TB] reset with operands in flight");
        applyStimulus(32'h0000_0E01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, w);
        applyStimulus(32'h0000_0E02, 32'hFFFF_FFFF, 32'hFFFF_FFFF, w);
        applyStimulus(32'h0000_0E03, 32'hFFFF_FFFF, 32'hFFFF_FFFF, w);
        rst = 1'b1;
        clearModel();
        @(negedge clk);
        checkOutput("in_ready_mid_rst", bus.in_ready, 1'b0);
        tick();
        rst = 1'b0;
        any_valid = 1'b0;
        @(negedge clk);
        checkOutput("in_ready_post_rst", bus.in_ready, 1'b1);
        checkOutput("post_rst_pkt_cnt", pkt_cnt, 16'd0);
        checkOutput("post_rst_drop_cnt", drop_cnt, 16'd0);
        repeat (10) tick();
        checkOutput("no_output_after_rst", any_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
